// File: rtl/pipeline_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_pkg
// Description : Shared types and constants for the pipeline data-hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_pkg;

    localparam int HZ_RD_W = 5;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               is_load;
    } hz_entry_t;

    // The youngest producer wins: EX/MEM data is newer than MEM/WB data.
    function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
        if (hit_ex)  return FWD_MEM;
        if (hit_mem) return FWD_WB;
        return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit_if
// Description : Decode-side request and hazard-control response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic                  id_rs1_used;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_rd_we;
    logic                  id_is_load;
    logic                  ex_flush;
    logic                  pc_hold;
    logic                  ifid_hold;
    logic                  idex_bubble;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_we, id_is_load, ex_flush,
        input  pc_hold, ifid_hold, idex_bubble, fwd_a_sel, fwd_b_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_we, id_is_load, ex_flush,
        output pc_hold, ifid_hold, idex_bubble, fwd_a_sel, fwd_b_sel, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_unit_tracker.sv
`default_nettype none
// ============================================================================
// Module      : hazard_tracker_pipe
// Description : Shift pipe of in-flight destination registers; entry 0 = EX.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_tracker_pipe
    import pipe_hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic                  clock,
    input  wire logic                  reset_n,
    input  hz_entry_t                  push,
    output hz_entry_t [DEPTH-1:0]      entries
);

    hz_entry_t [DEPTH-1:0] r_pipe;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign entries = r_pipe;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit
// Description : Scoreboard RAW-hazard stall/flush control beside decode.
//               Define HAZARD_FORWARD_EN for load-use-only stalls + forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_RD_W,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = 16
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    pipeline_hazard_unit_if.slave hz
);

    hz_entry_t [DEPTH-1:0] w_entries;
    hz_entry_t             w_push;
    logic [DEPTH-1:0]      w_rs1_hit;
    logic [DEPTH-1:0]      w_rs2_hit;
    logic [DEPTH-1:0]      w_is_load;
    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_issue;
    logic [1:0]            w_fwd_a;
    logic [1:0]            w_fwd_b;
    logic [1:0]            r_fwd_a;
    logic [1:0]            r_fwd_b;
    logic [CNT_W-1:0]      r_stall_cnt;

    hazard_tracker_pipe #(.DEPTH(DEPTH)) u_tracker (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .entries (w_entries)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign w_rs1_hit[g] = hz.id_rs1_used && (hz.id_rs1 != '0) && w_entries[g].valid
                              && (w_entries[g].rd == HZ_RD_W'(hz.id_rs1));
        assign w_rs2_hit[g] = hz.id_rs2_used && (hz.id_rs2 != '0) && w_entries[g].valid
                              && (w_entries[g].rd == HZ_RD_W'(hz.id_rs2));
        assign w_is_load[g] = w_entries[g].is_load;
    end

`ifdef HAZARD_FORWARD_EN
    logic w_unused_fwd;
    // Only a load still in EX cannot be bypassed; older results reach the ALU muxes.
    assign w_hazard     = (w_rs1_hit[0] | w_rs2_hit[0]) & w_is_load[0];
    assign w_fwd_a      = fwd_select(w_rs1_hit[0], w_rs1_hit[1]);
    assign w_fwd_b      = fwd_select(w_rs2_hit[0], w_rs2_hit[1]);
    assign w_unused_fwd = ^{w_is_load[DEPTH-1:1], w_rs1_hit[DEPTH-1:2], w_rs2_hit[DEPTH-1:2]};
`else
    logic w_unused_load;
    assign w_hazard      = |{w_rs1_hit, w_rs2_hit};
    assign w_fwd_a       = FWD_REG;
    assign w_fwd_b       = FWD_REG;
    assign w_unused_load = ^w_is_load;
`endif

    // A taken branch squashes the decode slot, so it overrides any hazard.
    assign w_stall = hz.id_valid & w_hazard & ~hz.ex_flush & reset_n;
    assign w_issue = hz.id_valid & ~w_hazard & ~hz.ex_flush;

    always_comb begin
        w_push = '0;
        if (w_issue) begin
            w_push.valid   = hz.id_rd_we & (hz.id_rd != '0);
            w_push.rd      = HZ_RD_W'(hz.id_rd);
            w_push.is_load = hz.id_is_load;
        end
    end

    assign hz.pc_hold     = w_stall;
    assign hz.ifid_hold   = w_stall;
    assign hz.idex_bubble = (w_stall | hz.ex_flush) & reset_n;
    assign hz.fwd_a_sel   = r_fwd_a;
    assign hz.fwd_b_sel   = r_fwd_b;
    assign hz.stall_count = r_stall_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd_a     <= FWD_REG;
            r_fwd_b     <= FWD_REG;
            r_stall_cnt <= '0;
        end else begin
            r_fwd_a <= w_issue ? w_fwd_a : FWD_REG;
            r_fwd_b <= w_issue ? w_fwd_b : FWD_REG;
            if (w_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_unit
// Description : Directed vector bench for pipeline_hazard_unit (both build modes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_unit;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       fl;
        logic       stall;
        logic       bub;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

`ifdef HAZARD_FORWARD_EN
    localparam int STALLS_PER = 1;
`else
    localparam int STALLS_PER = 3;
`endif

    logic clock;
    logic reset_n;
    int   n_cmp;
    int   n_fail;
    int   exp_stalls;
    vec_t tbl[$];

    pipeline_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) hz ();
    pipeline_hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(4))  hz_s ();

    pipeline_hazard_unit #(.REG_ADDR_W(5), .DEPTH(3), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz.slave)
    );

    pipeline_hazard_unit #(.REG_ADDR_W(5), .DEPTH(3), .CNT_W(4)) dut_sat (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz_s.slave)
    );

    assign hz_s.id_valid    = hz.id_valid;
    assign hz_s.id_rs1      = hz.id_rs1;
    assign hz_s.id_rs1_used = hz.id_rs1_used;
    assign hz_s.id_rs2      = hz.id_rs2;
    assign hz_s.id_rs2_used = hz.id_rs2_used;
    assign hz_s.id_rd       = hz.id_rd;
    assign hz_s.id_rd_we    = hz.id_rd_we;
    assign hz_s.id_is_load  = hz.id_is_load;
    assign hz_s.ex_flush    = hz.ex_flush;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic we, input logic ld, input logic fl,
                                input logic stall, input logic bub,
                                input logic [1:0] fa, input logic [1:0] fb);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
        t.we = we; t.ld = ld; t.fl = fl; t.stall = stall; t.bub = bub; t.fa = fa; t.fb = fb;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic fl);
        hz.id_valid = v;  hz.id_rs1 = rs1; hz.id_rs1_used = u1;
        hz.id_rs2 = rs2;  hz.id_rs2_used = u2; hz.id_rd = rd;
        hz.id_rd_we = we; hz.id_is_load = ld; hz.ex_flush = fl;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat_exp(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_cnt"}, 32'(hz.stall_count), exp_stalls);
        check({tag, "_cnt_sat"}, 32'(hz_s.stall_count), sat_exp(exp_stalls));
    endtask

    initial begin
        int cd;
        logic exp_st;
        n_cmp = 0; n_fail = 0; exp_stalls = 0;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

`ifdef HAZARD_FORWARD_EN
        //        v rs1 u1 rs2 u2 rd we ld fl  st bub fa fb
        tbl.push_back(mk(1,  1, 1,  2, 1,  5, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5, 1,  5, 1,  6, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5, 1,  6, 1,  7, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,  5, 1,  0, 1,  8, 1, 0, 0, 0, 0, 2, 1));
        tbl.push_back(mk(1,  8, 1,  7, 0,  9, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  9, 1,  9, 1, 10, 1, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1,  9, 1,  9, 1, 10, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 10, 1,  0, 0,  0, 0, 0, 0, 0, 0, 2, 2));
        tbl.push_back(mk(1,  1, 1,  0, 0, 11, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 11, 1,  1, 1, 12, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 12, 1, 11, 1, 13, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 13, 1,  0, 0, 14, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1,  0, 1, 14, 1, 15, 1, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1,  0, 1, 14, 1, 15, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  1, 1,  0, 0,  0, 1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1,  0, 1,  0, 1, 16, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
`else
        //        v rs1 u1 rs2 u2 rd we ld fl  st bub fa fb
        tbl.push_back(mk(1,  1, 1,  2, 1,  5, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5, 1,  1, 1,  6, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1,  5, 1,  1, 1,  6, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1,  5, 1,  1, 1,  6, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1,  5, 1,  1, 1,  6, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  1, 1,  2, 1,  0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  0, 1,  0, 1,  7, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  7, 0,  6, 1,  8, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1,  7, 0,  6, 1,  8, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  8, 1,  0, 0, 10, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 10, 1,  0, 1, 11, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 11, 1,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  1, 1,  0, 0, 12, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 12, 1, 11, 1, 13, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 12, 1, 11, 1, 13, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 12, 1, 11, 1, 13, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 12, 1, 11, 1, 13, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
`endif

        // Reset state, with a flush request that must stay masked.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_pc_hold", 32'(hz.pc_hold), 0);
        check("rst_ifid_hold", 32'(hz.ifid_hold), 0);
        check("rst_bubble", 32'(hz.idex_bubble), 0);
        check("rst_fwd_a", 32'(hz.fwd_a_sel), 0);
        check("rst_fwd_b", 32'(hz.fwd_b_sel), 0);
        check_counts("rst");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clock); #1;
            drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
                  tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].fl);
            @(negedge clock);
            check($sformatf("vec%0d_pc_hold", i), 32'(hz.pc_hold), 32'(tbl[i].stall));
            check($sformatf("vec%0d_ifid_hold", i), 32'(hz.ifid_hold), 32'(tbl[i].stall));
            check($sformatf("vec%0d_bubble", i), 32'(hz.idex_bubble), 32'(tbl[i].bub));
            check($sformatf("vec%0d_fwd_a", i), 32'(hz.fwd_a_sel), 32'(tbl[i].fa));
            check($sformatf("vec%0d_fwd_b", i), 32'(hz.fwd_b_sel), 32'(tbl[i].fb));
            check_counts($sformatf("vec%0d", i));
            if (tbl[i].stall) exp_stalls++;
        end

        // Asynchronous reset in the middle of a load-use stall.
        @(posedge clock); #1;
        drive(1, 1, 1, 0, 0, 20, 1, 1, 0);
        @(posedge clock); #1;
        drive(1, 20, 1, 20, 1, 21, 1, 0, 0);
        @(negedge clock);
        check("midrst_stall_before", 32'(hz.pc_hold), 1);
        #1;
        reset_n = 1'b0;
        hz.ex_flush = 1'b1;
        exp_stalls = 0;
        #1;
        check("midrst_pc_hold", 32'(hz.pc_hold), 0);
        check("midrst_ifid_hold", 32'(hz.ifid_hold), 0);
        check("midrst_bubble", 32'(hz.idex_bubble), 0);
        check_counts("midrst");
        @(posedge clock); #1;
        hz.ex_flush = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        check("postrst_pc_hold", 32'(hz.pc_hold), 0);
        check("postrst_bubble", 32'(hz.idex_bubble), 0);
        check_counts("postrst");

        repeat (3) begin
            @(posedge clock); #1;
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Self-dependent load chain drives both counters past the narrow one's ceiling.
        cd = 0;
        for (int c = 0; c < 80 && exp_stalls < 21; c++) begin
            @(posedge clock); #1;
            drive(1, 5, 1, 0, 0, 5, 1, 1, 0);
            @(negedge clock);
            exp_st = (cd > 0);
            check($sformatf("chain%0d_pc_hold", c), 32'(hz.pc_hold), 32'(exp_st));
            check_counts($sformatf("chain%0d", c));
            if (exp_st) begin
                exp_stalls++;
                cd--;
            end else begin
                cd = STALLS_PER;
            end
        end
        if (exp_stalls < 21) begin
            n_cmp++;
            n_fail++;
            $display("FAIL chain_budget: got %0d stalls, expected at least 21", exp_stalls);
        end
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("final_cnt", 32'(hz.stall_count), exp_stalls);
        check("final_cnt_sat", 32'(hz_s.stall_count), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
